iq_stream_packetizer: RTL and testbench

//   Multi-channel successor to the single AFE->FT600 sample path. Merges NUM_CH IQ sample

---
 rtl/sdr_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/iq_stream_packetizer.sv | 220 ++++++++++++++++++++++
 tb/tb_iq_stream_packetizer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR sample-path blocks.
//   PKT_SYNC / HDR_*_LSB : packet header layout (sync[31:24], ch[23:16], seq[15:0])
//   clog2                : ceiling log2, usable in parameter expressions
//   pkt_state_e          : packetizer FSM encoding
package sdr_pkg;

    localparam logic [7:0] PKT_SYNC     = 8'hA5;
    localparam int         HDR_SYNC_LSB = 24;
    localparam int         HDR_CH_LSB   = 16;
    localparam int         HDR_SEQ_LSB  = 0;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } pkt_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       in  N   request vector
//   ptr       in  IW  index with highest priority this round
//   gnt       out N   one-hot grant
//   gnt_idx   out IW  index of the granted requester
//   gnt_valid out 1   any request granted
// The first request at or after ptr wins; the search wraps to index 0.
module rr_arbiter
    import sdr_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // First pass: requesters from ptr upward.
        for (int k = 0; k < N; k++) begin
            if (!gnt_valid && req[k] && (k >= int'(ptr))) begin
                gnt_valid = 1'b1;
                gnt[k]    = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
        // Second pass: wrap around to the requesters below ptr.
        for (int k = 0; k < N; k++) begin
            if (!gnt_valid && req[k] && (k < int'(ptr))) begin
                gnt_valid = 1'b1;
                gnt[k]    = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/iq_stream_packetizer.sv
// Merges NUM_CH IQ sample streams into one framed word stream for the FT600
// write side. Each packet is one header word {0.., A5, ch, seq16} followed by
// PKT_WORDS zero-extended samples from the same channel; channels are served
// round-robin among those that are enabled and hold a full packet.
//   clk, reset_n     ft_clk domain clock, asynchronous active-low reset
//   ch_en            per-channel enable mask (sampled only at arbitration)
//   s_data/s_valid   per-channel FIFO head and not-empty flag
//   s_enough         per-channel "holds at least PKT_WORDS samples"
//   s_ready          per-channel pop strobe (at most one bit high)
//   m_data/m_valid/m_ready/m_last  output word stream
//   busy, cur_ch     packet in flight and the channel being served
//
// Handshake: a word moves on a cycle where m_valid && m_ready. While m_valid is
// high and m_ready low, m_data and m_last are held unchanged. The output is a
// single register slot; it is free when it is empty or being drained this cycle.
module iq_stream_packetizer
    import sdr_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int IQ_PAIR_WIDTH = 24,
    parameter int FT_DATA_WIDTH = 32,
    parameter int PKT_WORDS     = 32,
    parameter int SEQ_WIDTH     = 16,
    localparam int CH_W         = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_CH-1:0]               ch_en,
    input  logic [NUM_CH*IQ_PAIR_WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]               s_valid,
    input  logic [NUM_CH-1:0]               s_enough,
    output logic [NUM_CH-1:0]               s_ready,
    output logic [FT_DATA_WIDTH-1:0]        m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            m_last,
    output logic                            busy,
    output logic [CH_W-1:0]                 cur_ch
);

    localparam int                WCNT_W   = clog2(PKT_WORDS + 1);
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(PKT_WORDS - 1);
    localparam logic [WCNT_W-1:0] ALL_WORDS = WCNT_W'(PKT_WORDS);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    pkt_state_e                 state_q, state_d;
    logic [CH_W-1:0]            cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [SEQ_WIDTH-1:0]       seq_q [NUM_CH];
    logic [SEQ_WIDTH-1:0]       seq_d [NUM_CH];
    logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
    logic [FT_DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                       m_valid_q, m_valid_d;
    logic                       m_last_q, m_last_d;
    logic                       busy_q, busy_d;

    logic [NUM_CH-1:0]          gnt;
    logic [CH_W-1:0]            gnt_idx;
    logic                       gnt_valid;

    logic                       cur_valid;
    logic [IQ_PAIR_WIDTH-1:0]   cur_sample;
    logic [SEQ_WIDTH-1:0]       gnt_seq;
    logic [15:0]                hdr_seq;
    logic [7:0]                 hdr_ch;
    logic [FT_DATA_WIDTH-1:0]   hdr_word;
    logic                       slot_free;
    logic                       pop;

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (CH_W)
    ) u_arb (
        .req       (ch_en & s_enough),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Per-channel muxing done with compare loops so that NUM_CH == 1 needs no
    // special case for the channel index width.
    always_comb begin
        cur_valid  = 1'b0;
        cur_sample = '0;
        gnt_seq    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch_q == CH_W'(k)) begin
                cur_valid  = s_valid[k];
                cur_sample = s_data[k*IQ_PAIR_WIDTH +: IQ_PAIR_WIDTH];
            end
            if (gnt[k]) begin
                gnt_seq = seq_q[k];
            end
        end
    end

    // Header for the channel being granted; only the low 16 seq bits fit.
    always_comb begin
        hdr_seq                       = '0;
        hdr_seq[SEQ_WIDTH-1:0]        = gnt_seq;
        hdr_ch                        = '0;
        hdr_ch[CH_W-1:0]              = gnt_idx;
        hdr_word                      = '0;
        hdr_word[HDR_SYNC_LSB +: 8]   = PKT_SYNC;
        hdr_word[HDR_CH_LSB +: 8]     = hdr_ch;
        hdr_word[HDR_SEQ_LSB +: 16]   = hdr_seq;
    end

    // Pop only while the packet still needs samples, so exactly PKT_WORDS
    // samples leave the FIFO per packet.
    assign slot_free = !m_valid_q || m_ready;
    assign pop       = (state_q == ST_PAY) && cur_valid && slot_free && (wcnt_q != ALL_WORDS);

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            s_ready[k] = pop && (cur_ch_q == CH_W'(k));
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        rr_ptr_d  = rr_ptr_q;
        wcnt_d    = wcnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        busy_d    = busy_q;
        for (int k = 0; k < NUM_CH; k++) begin
            seq_d[k] = seq_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                // Output slot is always empty here, so the header is loaded
                // directly and appears on the next cycle.
                if (gnt_valid) begin
                    cur_ch_d  = gnt_idx;
                    busy_d    = 1'b1;
                    m_data_d  = hdr_word;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    state_d   = ST_HDR;
                end
            end

            ST_HDR: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    wcnt_d    = '0;
                    state_d   = ST_PAY;
                end
            end

            ST_PAY: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (cur_ch_q == CH_W'(k)) begin
                                seq_d[k] = seq_q[k] + SEQ_WIDTH'(1);
                            end
                        end
                        rr_ptr_d = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + CH_W'(1);
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                // A missing sample simply leaves the slot empty (bubble).
                if (pop) begin
                    m_data_d  = FT_DATA_WIDTH'(cur_sample);
                    m_valid_d = 1'b1;
                    m_last_d  = (wcnt_q == LAST_IDX);
                    wcnt_d    = wcnt_q + WCNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cur_ch_q  <= '0;
            rr_ptr_q  <= '0;
            wcnt_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                seq_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            rr_ptr_q  <= rr_ptr_d;
            wcnt_q    <= wcnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            for (int k = 0; k < NUM_CH; k++) begin
                seq_q[k] <= seq_d[k];
            end
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign cur_ch  = cur_ch_q;

endmodule

// File: tb/tb_iq_stream_packetizer.sv
// Directed bench for iq_stream_packetizer. Main DUT: NUM_CH=2, PKT_WORDS=4.
// Second DUT: NUM_CH=1, PKT_WORDS=1, SEQ_WIDTH=2, used to reach the sequence
// counter wrap in a handful of packets.
module tb_iq_stream_packetizer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic [1:0]  ch_en = 2'b00;
    logic [47:0] s_data = '0;
    logic [1:0]  s_valid = 2'b00;
    logic [1:0]  s_enough = 2'b00;
    logic [1:0]  s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        busy;
    logic        cur_ch;

    iq_stream_packetizer #(
        .NUM_CH(2), .IQ_PAIR_WIDTH(24), .FT_DATA_WIDTH(32), .PKT_WORDS(4), .SEQ_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .s_data(s_data), .s_valid(s_valid),
        .s_enough(s_enough), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .cur_ch(cur_ch)
    );

    // ---------------- wrap DUT ----------------
    logic        b_ch_en = 1'b0;
    logic [23:0] b_s_data = '0;
    logic        b_s_valid = 1'b0;
    logic        b_s_enough = 1'b0;
    logic        b_s_ready;
    logic [31:0] b_m_data;
    logic        b_m_valid;
    logic        b_m_ready = 1'b0;
    logic        b_m_last;
    logic        b_busy;
    logic        b_cur_ch;

    iq_stream_packetizer #(
        .NUM_CH(1), .IQ_PAIR_WIDTH(24), .FT_DATA_WIDTH(32), .PKT_WORDS(1), .SEQ_WIDTH(2)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .ch_en(b_ch_en), .s_data(b_s_data), .s_valid(b_s_valid),
        .s_enough(b_s_enough), .s_ready(b_s_ready), .m_data(b_m_data), .m_valid(b_m_valid),
        .m_ready(b_m_ready), .m_last(b_m_last), .busy(b_busy), .cur_ch(b_cur_ch)
    );

    // ---------------- source model / scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [23:0] q0[$];
    logic [23:0] q1[$];
    logic [1:0]  src_on = 2'b11;
    logic [31:0] obs_data[$];
    logic        obs_last[$];
    int          obs_cyc[$];
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    int          cyc = 0;
    int          pop_cnt0 = 0;
    int          pop_cnt1 = 0;
    int          both_ready = 0;
    int          stall_hold_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    // ---------------- driver tasks ----------------
    // One clock: drive inputs at the falling edge, then observe; everything
    // observed here is what the DUT acts on at the following rising edge.
    task automatic tick(input logic mr);
        @(negedge clk);
        m_ready       = mr;
        s_valid[0]    = (q0.size() > 0) && src_on[0];
        s_valid[1]    = (q1.size() > 0) && src_on[1];
        s_data[23:0]  = (q0.size() > 0) ? q0[0] : 24'h0;
        s_data[47:24] = (q1.size() > 0) ? q1[0] : 24'h0;
        s_enough[0]   = (q0.size() >= 4);
        s_enough[1]   = (q1.size() >= 4);
        #1;
        cyc++;
        if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
            stall_hold_err++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) begin
            obs_data.push_back(m_data);
            obs_last.push_back(m_last);
            obs_cyc.push_back(cyc);
        end
        if (s_ready[0] && s_ready[1]) both_ready++;
        if (s_ready[0]) begin void'(q0.pop_front()); pop_cnt0++; end
        if (s_ready[1]) begin void'(q1.pop_front()); pop_cnt1++; end
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int i;
        i = 0;
        while (obs_data.size() < n && i < budget) begin
            tick(1'b1);
            i++;
        end
        ok = (obs_data.size() >= n);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ch_en   = 2'b00;
        src_on  = 2'b11;
        q0.delete(); q1.delete();
        obs_data.delete(); obs_last.delete(); obs_cyc.delete();
        exp_q.delete(); exp_last_q.delete();
        pop_cnt0 = 0; pop_cnt1 = 0; both_ready = 0; stall_hold_err = 0; prev_stall = 1'b0;
        repeat (3) tick(1'b1);
        reset_n = 1'b1;
    endtask

    task automatic load_q0(input logic [23:0] first, input int n);
        for (int i = 0; i < n; i++) q0.push_back(first + 24'(i));
    endtask

    task automatic load_q1(input logic [23:0] first, input int n);
        for (int i = 0; i < n; i++) q1.push_back(first + 24'(i));
    endtask

    // Expected packet: header then samples first..first+3, m_last on the 4th.
    task automatic expect_pkt(input logic [31:0] hdr, input logic [23:0] first);
        exp_q.push_back(hdr); exp_last_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({8'h00, first + 24'(i)});
            exp_last_q.push_back(i == 3);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        q0.delete(); q1.delete();
        obs_data.delete(); obs_last.delete(); obs_cyc.delete();
        ch_en = 2'b11;
        load_q0(24'h000100, 4);
        load_q1(24'h000200, 4);
        repeat (2) tick(1'b1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL rst_s_ready: got %b want 00", s_ready); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rst_m_data: got %h want 0", m_data); end
        checks++; if (cur_ch !== 1'b0) begin errors++; $display("FAIL rst_cur_ch: got %b want 0", cur_ch); end
        checks++; if (b_m_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL rst_wrap_idle: got %b%b want 00", b_m_valid, b_busy); end
        reset_n = 1'b1;
        // Requests are already present: grant on the first edge, header right after.
        tick(1'b0);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'hA5000000) begin errors++; $display("FAIL rst_first_hdr: got v=%b %h want v=1 a5000000", m_valid, m_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_first_busy: got %b want 1", busy); end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        ch_en = 2'b01;
        load_q0(24'h000001, 8);
        expect_pkt(32'hA5000000, 24'h000001);
        expect_pkt(32'hA5000001, 24'h000005);
        run_until(10, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d words want 10", obs_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_data.size() <= i || obs_data[i] !== exp_q[i] || obs_last[i] !== exp_last_q[i]) begin
                errors++;
                $display("FAIL single_word[%0d]: got %h last=%b want %h last=%b", i,
                         (obs_data.size() > i) ? obs_data[i] : 32'hx, (obs_last.size() > i) ? obs_last[i] : 1'bx,
                         exp_q[i], exp_last_q[i]);
            end
        end
        checks++; if (pop_cnt0 !== 8) begin errors++; $display("FAIL single_pops: got %0d want 8", pop_cnt0); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        ch_en = 2'b11;
        load_q0(24'h000010, 8);
        load_q1(24'h000020, 8);
        expect_pkt(32'hA5000000, 24'h000010);
        expect_pkt(32'hA5010000, 24'h000020);
        expect_pkt(32'hA5000001, 24'h000014);
        expect_pkt(32'hA5010001, 24'h000024);
        run_until(20, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d words want 20", obs_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_data.size() <= i || obs_data[i] !== exp_q[i] || obs_last[i] !== exp_last_q[i]) begin
                errors++;
                $display("FAIL rr_word[%0d]: got %h want %h", i,
                         (obs_data.size() > i) ? obs_data[i] : 32'hx, exp_q[i]);
            end
        end
        // Last word -> next header: at most one idle cycle in between.
        for (int p = 1; p < 4; p++) begin
            checks++;
            if (obs_cyc.size() <= 5*p || obs_cyc[5*p] - obs_cyc[5*p-1] > 2) begin
                errors++;
                $display("FAIL rr_gap[%0d]: got %0d cycles want <=2", p,
                         (obs_cyc.size() > 5*p) ? obs_cyc[5*p] - obs_cyc[5*p-1] : -1);
            end
        end
        checks++; if (both_ready !== 0) begin errors++; $display("FAIL rr_onehot_ready: got %0d want 0", both_ready); end
    endtask

    task automatic test_backpressure();
        int i;
        do_reset();
        ch_en = 2'b01;
        load_q0(24'h000030, 4);
        expect_pkt(32'hA5000000, 24'h000030);
        i = 0;
        while (obs_data.size() < 5 && i < 80) begin
            tick(i[0]);
            i++;
        end
        checks++; if (obs_data.size() < 5) begin errors++; $display("FAIL bp_timeout: got %0d words want 5", obs_data.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_data.size() <= k || obs_data[k] !== exp_q[k] || obs_last[k] !== exp_last_q[k]) begin
                errors++;
                $display("FAIL bp_word[%0d]: got %h want %h", k,
                         (obs_data.size() > k) ? obs_data[k] : 32'hx, exp_q[k]);
            end
        end
        repeat (4) tick(1'b1);
        checks++; if (stall_hold_err !== 0) begin errors++; $display("FAIL bp_hold: got %0d changes want 0", stall_hold_err); end
        checks++; if (pop_cnt0 !== 4) begin errors++; $display("FAIL bp_pops: got %0d want 4", pop_cnt0); end
        checks++; if (obs_data.size() !== 5) begin errors++; $display("FAIL bp_extra: got %0d words want 5", obs_data.size()); end
    endtask

    task automatic test_bubble();
        bit ok;
        do_reset();
        ch_en = 2'b01;
        load_q0(24'h000040, 4);
        expect_pkt(32'hA5000000, 24'h000040);
        run_until(2, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bub_start_timeout: got %0d words want 2", obs_data.size()); end
        src_on = 2'b00;
        tick(1'b1);
        for (int g = 0; g < 3; g++) begin
            if (g == 2) src_on = 2'b11;
            tick(1'b1);
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL bub_valid[%0d]: got %b want 0", g, m_valid); end
        end
        run_until(5, 40, ok);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_data.size() <= k || obs_data[k] !== exp_q[k] || obs_last[k] !== exp_last_q[k]) begin
                errors++;
                $display("FAIL bub_word[%0d]: got %h last=%b want %h last=%b", k,
                         (obs_data.size() > k) ? obs_data[k] : 32'hx, (obs_last.size() > k) ? obs_last[k] : 1'bx,
                         exp_q[k], exp_last_q[k]);
            end
        end
    endtask

    task automatic test_ch_en();
        bit ok;
        do_reset();
        ch_en = 2'b01;
        load_q1(24'h000050, 8);
        repeat (20) tick(1'b1);
        checks++; if (obs_data.size() !== 0 || pop_cnt1 !== 0) begin errors++; $display("FAIL en_masked: got %0d words %0d pops want 0 0", obs_data.size(), pop_cnt1); end
        load_q0(24'h000060, 4);
        expect_pkt(32'hA5000000, 24'h000060);
        run_until(1, 20, ok);
        ch_en = 2'b00;
        checks++; if (busy !== 1'b1 || cur_ch !== 1'b0) begin errors++; $display("FAIL en_busy: got busy=%b ch=%b want 1 0", busy, cur_ch); end
        run_until(5, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL en_complete: got %0d words want 5", obs_data.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_data.size() <= k || obs_data[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL en_word[%0d]: got %h want %h", k, (obs_data.size() > k) ? obs_data[k] : 32'hx, exp_q[k]);
            end
        end
        repeat (10) tick(1'b1);
        checks++; if (busy !== 1'b0 || obs_data.size() !== 5) begin errors++; $display("FAIL en_idle: got busy=%b words=%0d want 0 5", busy, obs_data.size()); end
        checks++; if (pop_cnt1 !== 0 || q1.size() !== 8) begin errors++; $display("FAIL en_ch1_untouched: got %0d pops want 0", pop_cnt1); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        ch_en = 2'b01;
        load_q0(24'h000070, 8);
        run_until(2, 40, ok);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b want 1", m_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async_ctrl: got v=%b l=%b b=%b want 000", m_valid, m_last, busy); end
        checks++; if (m_data !== 32'h0 || s_ready !== 2'b00) begin errors++; $display("FAIL rm_async_data: got %h %b want 0 00", m_data, s_ready); end
        q0.delete();
        obs_data.delete(); obs_last.delete(); obs_cyc.delete();
        repeat (2) tick(1'b1);
        load_q0(24'h000080, 4);
        reset_n = 1'b1;
        expect_pkt(32'hA5000000, 24'h000080);
        run_until(5, 40, ok);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_data.size() <= k || obs_data[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rm_word[%0d]: got %h want %h", k, (obs_data.size() > k) ? obs_data[k] : 32'hx, exp_q[k]);
            end
        end
    endtask

    task automatic test_seq_wrap();
        logic [31:0] w_data[$];
        logic        w_last[$];
        int          i;
        b_ch_en = 1'b1; b_s_valid = 1'b1; b_s_enough = 1'b1;
        b_s_data = 24'h00ABCD; b_m_ready = 1'b1;
        i = 0;
        while (w_data.size() < 10 && i < 100) begin
            @(negedge clk); #1;
            if (b_m_valid && b_m_ready) begin
                w_data.push_back(b_m_data);
                w_last.push_back(b_m_last);
            end
            i++;
        end
        b_ch_en = 1'b0;
        checks++; if (w_data.size() < 10) begin errors++; $display("FAIL wrap_timeout: got %0d words want 10", w_data.size()); end
        // SEQ_WIDTH=2: 0,1,2,3 then back to 0.
        for (int p = 0; p < 5; p++) begin
            logic [31:0] eh;
            eh = 32'hA5000000 | 32'(p % 4);
            checks++;
            if (w_data.size() <= 2*p+1 || w_data[2*p] !== eh || w_data[2*p+1] !== 32'h0000ABCD
                || w_last[2*p] !== 1'b0 || w_last[2*p+1] !== 1'b1) begin
                errors++;
                $display("FAIL wrap_pkt[%0d]: got %h/%h want %h/0000abcd", p,
                         (w_data.size() > 2*p) ? w_data[2*p] : 32'hx,
                         (w_data.size() > 2*p+1) ? w_data[2*p+1] : 32'hx, eh);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_bubble();
        test_ch_en();
        test_reset_mid();
        test_seq_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
